// File: rtl/axi_stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS AXI-Stream sources onto one master port.
// A grant is locked from the first beat of a packet until its tlast handshake.
`timescale 1ns/1ps
module axi_stream_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int BYTE_WIDTH = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_INPUTS-1:0]              s_tvalid,
  output logic [NUM_INPUTS-1:0]              s_tready,
  input  logic [NUM_INPUTS*8*BYTE_WIDTH-1:0] s_tdata,
  input  logic [NUM_INPUTS*BYTE_WIDTH-1:0]   s_tkeep,
  input  logic [NUM_INPUTS*BYTE_WIDTH-1:0]   s_tstrb,
  input  logic [NUM_INPUTS-1:0]              s_tlast,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               m_tlast,
  output logic [8*BYTE_WIDTH-1:0]            m_tdata,
  output logic [BYTE_WIDTH-1:0]              m_tkeep,
  output logic [BYTE_WIDTH-1:0]              m_tstrb,
  output logic [SEL_WIDTH-1:0]               m_tid,
  output logic [NUM_INPUTS-1:0]              grant,
  output logic                               busy,
  output logic [15:0]                        pkt_count
);

  localparam int                 DATA_W = 8 * BYTE_WIDTH;
  localparam logic [SEL_WIDTH:0] NUM_W  = (SEL_WIDTH+1)'(NUM_INPUTS);

  typedef enum logic {IDLE, PASS} state_t;

  state_t               state_reg, state_next;
  logic [SEL_WIDTH-1:0] sel_reg, sel_next;
  logic [SEL_WIDTH-1:0] ptr_reg, ptr_next;
  logic [15:0]          pkt_count_reg, pkt_count_next;
  logic [SEL_WIDTH-1:0] pick;
  logic                 last_xfer;

  // Modular add that keeps indices inside 0..NUM_INPUTS-1 for any NUM_INPUTS.
  function automatic logic [SEL_WIDTH-1:0] wrap_add(input logic [SEL_WIDTH-1:0] base,
                                                    input logic [SEL_WIDTH:0]   offset);
    logic [SEL_WIDTH:0] sum;
    sum = {1'b0, base} + offset;
    if (sum >= NUM_W) sum = sum - NUM_W;
    return sum[SEL_WIDTH-1:0];
  endfunction

  // Descending scan so the requester closest to ptr wins.
  always_comb begin
    pick = ptr_reg;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (s_tvalid[wrap_add(ptr_reg, (SEL_WIDTH+1)'(k))])
        pick = wrap_add(ptr_reg, (SEL_WIDTH+1)'(k));
    end
  end

  assign last_xfer = (state_reg == PASS) && s_tvalid[sel_reg] && m_tready && s_tlast[sel_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      ptr_reg       <= '0;
      pkt_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      ptr_reg       <= ptr_next;
      pkt_count_reg <= pkt_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    ptr_next       = ptr_reg;
    pkt_count_next = pkt_count_reg;
    case (state_reg)
      IDLE: begin
        if (|s_tvalid) begin
          state_next = PASS;
          sel_next   = pick;
        end
      end
      PASS: begin
        if (last_xfer) begin
          state_next     = IDLE;
          ptr_next       = wrap_add(sel_reg, (SEL_WIDTH+1)'(1));
          pkt_count_next = pkt_count_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Payload always follows sel; only the handshake is gated by state.
  always_comb begin
    busy      = (state_reg == PASS);
    m_tvalid  = busy && s_tvalid[sel_reg];
    m_tlast   = s_tlast[sel_reg];
    m_tdata   = s_tdata[sel_reg*DATA_W +: DATA_W];
    m_tkeep   = s_tkeep[sel_reg*BYTE_WIDTH +: BYTE_WIDTH];
    m_tstrb   = s_tstrb[sel_reg*BYTE_WIDTH +: BYTE_WIDTH];
    m_tid     = sel_reg;
    pkt_count = pkt_count_reg;
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_port
    assign grant[gi]    = (state_reg == PASS) && (sel_reg == SEL_WIDTH'(gi));
    assign s_tready[gi] = grant[gi] && m_tready;
  end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Bench for axi_stream_rr_arbiter: constant vector table, hand sequences for
// multi-cycle cases, and randomized traffic against a packet-level reference model.
`timescale 1ns/1ps
module tb_axi_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int BW = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*BW-1:0] s_tkeep, s_tstrb;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [BW-1:0] m_tkeep, m_tstrb;
  logic [SW-1:0] m_tid;
  logic [N-1:0]  grant;
  logic          busy;
  logic [15:0]   pkt_count;

  int checks = 0;
  int errors = 0;

  // Reference model: owner of the locked packet (-1 = none), rotation start, packet count.
  int owner = -1;
  int mptr  = 0;
  int mcnt  = 0;

  axi_stream_rr_arbiter #(.NUM_INPUTS(N), .BYTE_WIDTH(BW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tstrb(s_tstrb), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tstrb(m_tstrb), .m_tid(m_tid),
    .grant(grant), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    mptr  = 0;
    mcnt  = 0;
  endtask

  task automatic model_compare();
    logic [N-1:0] eg;
    eg = '0;
    if (owner >= 0) eg[owner] = 1'b1;
    check("grant", 64'(grant), 64'(eg));
    check("busy", 64'(busy), 64'(owner >= 0));
    check("m_tvalid", 64'(m_tvalid), 64'(owner >= 0 && s_tvalid[owner]));
    check("s_tready", 64'(s_tready), m_tready ? 64'(eg) : 64'(0));
    check("pkt_count", 64'(pkt_count), 64'(mcnt));
    if (owner >= 0) begin
      check("m_tid", 64'(m_tid), 64'(owner));
      check("m_tdata", 64'(m_tdata), 64'(s_tdata[owner*DW +: DW]));
      check("m_tkeep", 64'(m_tkeep), 64'(s_tkeep[owner*BW +: BW]));
      check("m_tstrb", 64'(m_tstrb), 64'(s_tstrb[owner*BW +: BW]));
      check("m_tlast", 64'(m_tlast), 64'(s_tlast[owner]));
    end
  endtask

  task automatic model_update();
    bit found;
    if (reset) begin
      model_reset();
    end else if (owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && s_tvalid[(mptr + k) % N]) begin
          owner = (mptr + k) % N;
          found = 1;
        end
      end
    end else if (s_tvalid[owner] && m_tready && s_tlast[owner]) begin
      mcnt  = (mcnt + 1) % 65536;
      mptr  = (owner + 1) % N;
      owner = -1;
    end
  endtask

  // Inputs are driven at the falling edge; compare, clock, advance the model.
  task automatic step();
    #1;
    model_compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    model_reset();
    s_tvalid = '0;
    s_tlast  = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_grant(input string name, input logic [N-1:0] g);
    #1;
    check(name, 64'(grant), 64'(g));
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         r;
    logic [N-1:0] g;
    logic [N-1:0] sr;
    logic         mv;
    int           tid;
  } vec_t;

  vec_t tbl[14];
  int   exp_order[5] = '{0, 1, 2, 3, 0};
  int   beats[N];
  int   cyc, hs;
  logic [SW-1:0] order[$];

  initial begin
    tbl[0]  = '{4'b1010, 4'b1010, 1'b1, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[1]  = '{4'b1010, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b1, 1};
    tbl[2]  = '{4'b1010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1};
    tbl[3]  = '{4'b1010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[4]  = '{4'b1010, 4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 3};
    tbl[5]  = '{4'b1010, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 3};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[7]  = '{4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b0, 1};
    tbl[9]  = '{4'b0001, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b0, 1};
    tbl[10] = '{4'b0011, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1};
    tbl[11] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[12] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 0};
    tbl[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0};

    reset    = 1'b1;
    s_tvalid = 4'hF;
    s_tlast  = '0;
    m_tready = 1'b1;
    s_tdata  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    s_tkeep  = 16'hF8C1;
    s_tstrb  = 16'h3A5F;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tready", 64'(s_tready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_count", 64'(pkt_count), 64'(0));
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    // Vector table: one-cycle arbitration latency, lock, bubble, wrap-around reselection.
    for (int i = 0; i < 14; i++) begin
      s_tvalid = tbl[i].v;
      s_tlast  = tbl[i].l;
      m_tready = tbl[i].r;
      #1;
      check($sformatf("vec%0d_grant", i), 64'(grant), 64'(tbl[i].g));
      check($sformatf("vec%0d_sready", i), 64'(s_tready), 64'(tbl[i].sr));
      check($sformatf("vec%0d_mvalid", i), 64'(m_tvalid), 64'(tbl[i].mv));
      if (tbl[i].g != 0) check($sformatf("vec%0d_tid", i), 64'(m_tid), 64'(tbl[i].tid));
      step();
    end
    check("vec_pkt_count", 64'(pkt_count), 64'(4));

    // Four sources streaming 3-beat packets back to back.
    do_reset();
    s_tvalid = 4'hF;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) beats[i] = 0;
    cyc = 0;
    while (pkt_count != 16'd5 && cyc < 40) begin
      for (int i = 0; i < N; i++) s_tlast[i] = (beats[i] == 2);
      #1;
      if (m_tvalid && m_tready && m_tlast) order.push_back(m_tid);
      hs = owner;
      step();
      cyc++;
      if (hs >= 0) beats[hs] = (beats[hs] == 2) ? 0 : beats[hs] + 1;
    end
    check("stream_cycles", 64'(cyc), 64'(20));
    check("stream_pkt_count", 64'(pkt_count), 64'(5));
    check("stream_order_len", 64'(order.size()), 64'(5));
    for (int i = 0; i < 5 && i < order.size(); i++)
      check($sformatf("stream_order%0d", i), 64'(order[i]), 64'(exp_order[i]));

    // Lock: source 2 raises tvalid while source 0 is mid-packet.
    do_reset();
    s_tvalid = 4'b0001;
    s_tlast  = 4'b0000;
    m_tready = 1'b1;
    step();
    expect_grant("lock_beat1", 4'b0001);
    step();
    s_tvalid = 4'b0101;
    expect_grant("lock_beat2", 4'b0001);
    step();
    expect_grant("lock_beat3", 4'b0001);
    step();
    s_tlast = 4'b0001;
    expect_grant("lock_beat4", 4'b0001);
    step();
    s_tvalid = 4'b0100;
    s_tlast  = 4'b0000;
    expect_grant("lock_dead", 4'b0000);
    step();
    expect_grant("lock_next", 4'b0100);

    // Backpressure: master stalls for five cycles on a held beat.
    s_tdata[2*DW +: DW] = 32'hDEADBEEF;
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall%0d_sready", i), 64'(s_tready), 64'(0));
      check($sformatf("stall%0d_tdata", i), 64'(m_tdata), 64'(32'hDEADBEEF));
      check($sformatf("stall%0d_grant", i), 64'(grant), 64'(4'b0100));
      step();
    end
    m_tready = 1'b1;
    s_tlast  = 4'b0100;
    step();
    s_tvalid = 4'hF;
    s_tlast  = 4'h0;
    expect_grant("stall_idle", 4'b0000);
    step();
    expect_grant("stall_ptr_next", 4'b1000);
    step();
    m_tready = 1'b0;

    // Reset pulsed during a packet.
    do_reset();
    m_tready = 1'b1;
    s_tvalid = 4'b0010;
    s_tlast  = 4'b0010;
    step();
    step();
    s_tlast = 4'b0000;
    step();
    step();
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_tvalid", 64'(m_tvalid), 64'(0));
    check("rstmid_tready", 64'(s_tready), 64'(0));
    check("rstmid_count", 64'(pkt_count), 64'(0));
    check("rstmid_grant", 64'(grant), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    s_tvalid = 4'b0100;
    step();
    expect_grant("rstmid_regrant", 4'b0100);
    s_tlast = 4'b0100;
    step();

    // Packet counter wrap: preload all-ones while idle, then one packet.
    s_tvalid = '0;
    s_tlast  = '0;
    step();
    force dut.pkt_count_reg = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.pkt_count_reg;
    mcnt = 65535;
    #1;
    check("wrap_preload", 64'(pkt_count), 64'(16'hFFFF));
    s_tvalid = 4'b0001;
    s_tlast  = 4'b0001;
    step();
    step();
    s_tvalid = '0;
    #1;
    check("wrap_zero", 64'(pkt_count), 64'(0));
    step();

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 499) == 0);
      if (reset) model_reset();
      s_tvalid = N'($urandom);
      for (int i = 0; i < N; i++) s_tlast[i] = ($urandom_range(0, 3) == 0);
      m_tready = ($urandom_range(0, 3) != 0);
      s_tdata  = {$urandom, $urandom, $urandom, $urandom};
      s_tkeep  = 16'($urandom);
      s_tstrb  = 16'($urandom);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
